// File: rtl/b_registradores_banked.sv
// ---------------------------------------------------------------------------
// b_registradores_banked
// Register file with per-mode banked upper registers, a link write port,
// a NZCV/mode status register and three registered read ports.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> reads that collide with a same-edge write return the new data,
//                and status reads return the value being written.
//   undefined -> reads return the pre-write contents (default build).
// ---------------------------------------------------------------------------
module b_registradores_banked #(
   parameter int unsigned  DATA_W    = 32,
   parameter int unsigned  ADDR_W    = 5,
   parameter int unsigned  N_BANKS   = 4,
   parameter int unsigned  BANK_BASE = 29,
   localparam int unsigned MODE_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rn,
   input  logic [ADDR_W-1:0] rm,
   input  logic [ADDR_W-1:0] rs,
   input  logic              rd_en,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] in_dados,
   input  logic              sinal_link,
   input  logic [DATA_W-1:0] in_link,
   input  logic              cpsr_write,
   input  logic [3:0]        in_cpsr,
   input  logic [MODE_W-1:0] in_mode,
   output logic [DATA_W-1:0] dado_um,
   output logic [DATA_W-1:0] dado_dois,
   output logic [DATA_W-1:0] dado_tres,
   output logic [3:0]        out_cpsr,
   output logic [MODE_W-1:0] out_mode
);

   localparam int unsigned NREGS   = 2 ** ADDR_W;
   localparam int unsigned NBANKED = NREGS - BANK_BASE;
   localparam int unsigned NWORDS  = BANK_BASE + N_BANKS * NBANKED;
   localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(NREGS - 1);

   // Map an architectural register index to its physical storage word.
   // Shared registers map 1:1; banked registers select the copy of mode m.
   function automatic logic [IDX_W-1:0] resolve(input logic [ADDR_W-1:0] a,
                                                input logic [MODE_W-1:0] m);
      int unsigned ai;
      int unsigned mi;
      ai = 32'(a);
      mi = 32'(m);
      if (ai < BANK_BASE) begin
         return IDX_W'(ai);
      end
      return IDX_W'(BANK_BASE + mi * NBANKED + (ai - BANK_BASE));
   endfunction

   // Storage and status state
   logic [DATA_W-1:0] mem_q [NWORDS];
   logic [DATA_W-1:0] mem_d [NWORDS];
   logic [3:0]        cpsr_q, cpsr_d;
   logic [MODE_W-1:0] mode_q, mode_d;

   // Registered outputs
   logic [DATA_W-1:0] dado_um_q,   dado_um_d;
   logic [DATA_W-1:0] dado_dois_q, dado_dois_d;
   logic [DATA_W-1:0] dado_tres_q, dado_tres_d;
   logic [3:0]        out_cpsr_q,  out_cpsr_d;
   logic [MODE_W-1:0] out_mode_q,  out_mode_d;

   // Resolved addresses, all against the mode held before the edge
   logic [IDX_W-1:0]  wr_idx_c;
   logic [IDX_W-1:0]  link_idx_c;
   logic [IDX_W-1:0]  um_idx_c;
   logic [IDX_W-1:0]  dois_idx_c;
   logic [IDX_W-1:0]  tres_idx_c;

   // Address resolution for write, link and the three read ports
   always_comb begin
      wr_idx_c   = resolve(rd, mode_q);
      link_idx_c = resolve(LINK_ADDR, mode_q);
      um_idx_c   = resolve(rn, mode_q);
      dois_idx_c = resolve(rm, mode_q);
      tres_idx_c = resolve(rs, mode_q);
   end

   // Next storage contents; link write is applied last so it wins a collision
   always_comb begin
      mem_d = mem_q;
      if (reg_write) begin
         mem_d[wr_idx_c] = in_dados;
      end
      if (sinal_link) begin
         mem_d[link_idx_c] = in_link;
      end
   end

   // Next status; out-of-range modes collapse to mode 0
   always_comb begin
      cpsr_d = cpsr_q;
      mode_d = mode_q;
      if (cpsr_write) begin
         cpsr_d = in_cpsr;
         if (32'(in_mode) >= N_BANKS) begin
            mode_d = '0;
         end else begin
            mode_d = in_mode;
         end
      end
   end

   // Next read outputs; hold while rd_en is low
   always_comb begin
      dado_um_d   = dado_um_q;
      dado_dois_d = dado_dois_q;
      dado_tres_d = dado_tres_q;
      out_cpsr_d  = out_cpsr_q;
      out_mode_d  = out_mode_q;
      if (rd_en) begin
`ifdef REGFILE_BYPASS_EN
         dado_um_d   = mem_d[um_idx_c];
         dado_dois_d = mem_d[dois_idx_c];
         dado_tres_d = mem_d[tres_idx_c];
         out_cpsr_d  = cpsr_d;
         out_mode_d  = mode_d;
`else
         dado_um_d   = mem_q[um_idx_c];
         dado_dois_d = mem_q[dois_idx_c];
         dado_tres_d = mem_q[tres_idx_c];
         out_cpsr_d  = cpsr_q;
         out_mode_d  = mode_q;
`endif
      end
   end

   // Storage array with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NWORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Status and output registers with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cpsr_q      <= '0;
         mode_q      <= '0;
         dado_um_q   <= '0;
         dado_dois_q <= '0;
         dado_tres_q <= '0;
         out_cpsr_q  <= '0;
         out_mode_q  <= '0;
      end else begin
         cpsr_q      <= cpsr_d;
         mode_q      <= mode_d;
         dado_um_q   <= dado_um_d;
         dado_dois_q <= dado_dois_d;
         dado_tres_q <= dado_tres_d;
         out_cpsr_q  <= out_cpsr_d;
         out_mode_q  <= out_mode_d;
      end
   end

   assign dado_um   = dado_um_q;
   assign dado_dois = dado_dois_q;
   assign dado_tres = dado_tres_q;
   assign out_cpsr  = out_cpsr_q;
   assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_b_registradores_banked.sv
// ---------------------------------------------------------------------------
// tb_b_registradores_banked
// Directed bench for the banked register file. A second instance with three
// banks exercises the out-of-range mode clamp, since a 4-bank mode port is
// only two bits wide and cannot carry an illegal value.
// ---------------------------------------------------------------------------
module tb_b_registradores_banked;

   logic        clock;
   logic        reset_n;
   logic [4:0]  rn, rm, rs, rd;
   logic        rd_en, reg_write, sinal_link, cpsr_write;
   logic [31:0] in_dados, in_link;
   logic [3:0]  in_cpsr;
   logic [1:0]  in_mode;

   logic [31:0] dado_um, dado_dois, dado_tres;
   logic [3:0]  out_cpsr;
   logic [1:0]  out_mode;

   logic [31:0] b_um, b_dois, b_tres;
   logic [3:0]  b_cpsr;
   logic [1:0]  b_mode;

   int n_chk  = 0;
   int n_pass = 0;

   b_registradores_banked u_dut (
      .clock(clock), .reset_n(reset_n),
      .rn(rn), .rm(rm), .rs(rs), .rd_en(rd_en),
      .reg_write(reg_write), .rd(rd), .in_dados(in_dados),
      .sinal_link(sinal_link), .in_link(in_link),
      .cpsr_write(cpsr_write), .in_cpsr(in_cpsr), .in_mode(in_mode),
      .dado_um(dado_um), .dado_dois(dado_dois), .dado_tres(dado_tres),
      .out_cpsr(out_cpsr), .out_mode(out_mode)
   );

   b_registradores_banked #(.N_BANKS(3)) u_dut3 (
      .clock(clock), .reset_n(reset_n),
      .rn(rn), .rm(rm), .rs(rs), .rd_en(rd_en),
      .reg_write(reg_write), .rd(rd), .in_dados(in_dados),
      .sinal_link(sinal_link), .in_link(in_link),
      .cpsr_write(cpsr_write), .in_cpsr(in_cpsr), .in_mode(in_mode),
      .dado_um(b_um), .dado_dois(b_dois), .dado_tres(b_tres),
      .out_cpsr(b_cpsr), .out_mode(b_mode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_write = 1'b1; rd = a; in_dados = d;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic rdp(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      rn = a; rm = b; rs = c; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic setmode(input logic [1:0] m);
      cpsr_write = 1'b1; in_cpsr = 4'h0; in_mode = m;
      tick();
      cpsr_write = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      rn = '0; rm = '0; rs = '0; rd = '0;
      rd_en = 1'b0; reg_write = 1'b0; sinal_link = 1'b0; cpsr_write = 1'b0;
      in_dados = '0; in_link = '0; in_cpsr = '0; in_mode = '0;

      // Reset state
      #12;
      chk("rst_um",   dado_um,   32'h0);
      chk("rst_dois", dado_dois, 32'h0);
      chk("rst_tres", dado_tres, 32'h0);
      chk("rst_cpsr", 32'(out_cpsr), 32'h0);
      chk("rst_mode", 32'(out_mode), 32'h0);
      reset_n = 1'b1;
      tick();

      // Basic write then read, one-cycle latency
      wr(5'd3, 32'hDEADBEEF);
      rdp(5'd3, 5'd0, 5'd3);
      chk("r3_um",   dado_um,   32'hDEADBEEF);
      chk("r0_dois", dado_dois, 32'h0);
      chk("r3_tres", dado_tres, 32'hDEADBEEF);

      // Banked r29 versus shared r5 across modes 0 and 2
      wr(5'd29, 32'h11);
      wr(5'd5,  32'h5A5A);
      setmode(2'd2);
      wr(5'd29, 32'h22);
      rdp(5'd29, 5'd5, 5'd30);
      chk("m2_r29",  dado_um,   32'h22);
      chk("m2_r5",   dado_dois, 32'h5A5A);
      chk("m2_r30",  dado_tres, 32'h0);
      chk("m2_mode", 32'(out_mode), 32'h2);
      setmode(2'd0);
      rdp(5'd29, 5'd5, 5'd29);
      chk("m0_r29",  dado_um,   32'h11);
      chk("m0_r5",   dado_dois, 32'h5A5A);
      chk("m0_r29b", dado_tres, 32'h11);
      chk("m0_mode", 32'(out_mode), 32'h0);

      // Link write beats general write on r31
      reg_write = 1'b1; rd = 5'd31; in_dados = 32'hAA;
      sinal_link = 1'b1; in_link = 32'hBB;
      tick();
      reg_write = 1'b0; sinal_link = 1'b0;
      rdp(5'd31, 5'd31, 5'd31);
      chk("lnk_r31", dado_um, 32'hBB);

      // Link in mode 1 lands in the mode-1 bank only; general write to r4 alongside
      setmode(2'd1);
      reg_write = 1'b1; rd = 5'd4; in_dados = 32'h44;
      sinal_link = 1'b1; in_link = 32'hCC;
      tick();
      reg_write = 1'b0; sinal_link = 1'b0;
      rdp(5'd31, 5'd4, 5'd29);
      chk("m1_r31", dado_um,   32'hCC);
      chk("m1_r4",  dado_dois, 32'h44);
      chk("m1_r29", dado_tres, 32'h0);
      setmode(2'd0);
      rdp(5'd31, 5'd4, 5'd3);
      chk("m0_r31", dado_um,   32'hBB);
      chk("m0_r4",  dado_dois, 32'h44);

      // Same-edge write and read of r7 on all ports
      wr(5'd7, 32'h33);
      reg_write = 1'b1; rd = 5'd7; in_dados = 32'h55;
      rn = 5'd7; rm = 5'd7; rs = 5'd7; rd_en = 1'b1;
      tick();
      reg_write = 1'b0; rd_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
      chk("byp_um",   dado_um,   32'h55);
      chk("byp_dois", dado_dois, 32'h55);
      chk("byp_tres", dado_tres, 32'h55);
`else
      chk("byp_um",   dado_um,   32'h33);
      chk("byp_dois", dado_dois, 32'h33);
      chk("byp_tres", dado_tres, 32'h33);
`endif
      rdp(5'd7, 5'd7, 5'd7);
      chk("r7_after", dado_um, 32'h55);

      // rd_en low holds outputs
      rn = 5'd3; rm = 5'd3; rs = 5'd3; rd_en = 1'b0;
      tick();
      tick();
      chk("hold_um",   dado_um,   32'h55);
      chk("hold_tres", dado_tres, 32'h55);

      // Status register: no update without cpsr_write
      in_cpsr = 4'hF; cpsr_write = 1'b0; rd_en = 1'b1;
      tick();
      chk("cpsr_nowr", 32'(out_cpsr), 32'h0);
      cpsr_write = 1'b1; in_mode = 2'd0;
      tick();
      cpsr_write = 1'b0;
`ifdef REGFILE_BYPASS_EN
      chk("cpsr_wr_edge", 32'(out_cpsr), 32'hF);
`else
      chk("cpsr_wr_edge", 32'(out_cpsr), 32'h0);
`endif
      tick();
      rd_en = 1'b0;
      chk("cpsr_wr", 32'(out_cpsr), 32'hF);

      // Mode clamp: 3 is legal with 4 banks, illegal with 3 banks
      cpsr_write = 1'b1; in_cpsr = 4'h5; in_mode = 2'd3;
      tick();
      cpsr_write = 1'b0;
      rdp(5'd0, 5'd0, 5'd0);
      chk("clamp_b3",   32'(b_mode),   32'h0);
      chk("clamp_b4",   32'(out_mode), 32'h3);
      chk("clamp_cpsr", 32'(b_cpsr),   32'h5);
      cpsr_write = 1'b1; in_mode = 2'd2;
      tick();
      cpsr_write = 1'b0;
      rdp(5'd0, 5'd0, 5'd0);
      chk("legal_b3", 32'(b_mode), 32'h2);
      setmode(2'd0);

      // Asynchronous reset mid-operation clears state and outputs at once
      wr(5'd1, 32'h99);
      rdp(5'd1, 5'd1, 5'd1);
      chk("r1_pre", dado_um, 32'h99);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_um",   dado_um,   32'h0);
      chk("arst_dois", dado_dois, 32'h0);
      chk("arst_cpsr", 32'(out_cpsr), 32'h0);
      #2;
      reset_n = 1'b1;
      tick();
      rdp(5'd1, 5'd3, 5'd29);
      chk("post_r1",  dado_um,   32'h0);
      chk("post_r3",  dado_dois, 32'h0);
      chk("post_r29", dado_tres, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
